// File: rtl/spi_slave_phy_sync.sv
// SPI slave PHY, fully oversampled in the system clock domain.
// SCLK, CS and MOSI are synchronised and edge-detected on clk; no logic runs on SCLK.
// Provides word-level rx pulses and a single-entry, flow-controlled tx holding register.
`timescale 1ns / 1ps

module spi_slave_phy_sync #(
  parameter int unsigned      WIDTH       = 8,
  parameter bit               CPOL        = 1'b0,
  parameter bit               CPHA        = 1'b0,
  parameter bit               MSB_FIRST   = 1'b1,
  parameter int unsigned      SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] TX_IDLE     = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             spi_cs,
  input  logic             spi_clk,
  input  logic             spi_mosi,
  output logic             spi_miso,
  output logic             spi_miso_oe,
  output logic             rx_valid,
  output logic [WIDTH-1:0] rx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  input  logic [WIDTH-1:0] tx_data,
  output logic             tx_underrun,
  output logic             frame_start,
  output logic             frame_end,
  output logic             frame_err
);

  localparam int unsigned CNT_W   = $clog2(WIDTH);
  localparam int unsigned FLUSH_W = $clog2(SYNC_STAGES + 1);
  localparam logic [CNT_W-1:0]   LAST_BIT   = CNT_W'(WIDTH - 1);
  localparam logic [FLUSH_W-1:0] FLUSH_DONE = FLUSH_W'(SYNC_STAGES);

  logic [SYNC_STAGES-1:0] cs_sync_q, sclk_sync_q, mosi_sync_q;
  logic                   sclk_dly_q;
  logic [FLUSH_W-1:0]     flush_cnt_q;
  logic                   cs_idle_q;   // previous cycle saw a genuine (flushed) CS high
  logic                   active_q;
  logic [CNT_W-1:0]       bit_cnt_q;
  logic [WIDTH-1:0]       rx_shift_q, tx_shift_q, hold_q;
  logic                   hold_full_q;

  logic             cs_s, sclk_s, mosi_s, flushed;
  logic             lead_edge, trail_edge, in_frame;
  logic             sample_evt, shift_evt, cs_fall, cs_rise, word_done, reload, hold_wr;
  logic [WIDTH-1:0] rx_next;

  // Edge and frame event decode from the synchronised inputs.
  always_comb begin
    cs_s       = cs_sync_q[SYNC_STAGES-1];
    sclk_s     = sclk_sync_q[SYNC_STAGES-1];
    mosi_s     = mosi_sync_q[SYNC_STAGES-1];
    flushed    = (flush_cnt_q == FLUSH_DONE);
    lead_edge  = (sclk_s != CPOL) && (sclk_dly_q == CPOL);
    trail_edge = (sclk_s == CPOL) && (sclk_dly_q != CPOL);
    // A CS rise in the same cycle as an SCLK edge drops the edge.
    in_frame   = active_q && !cs_s;
    sample_evt = in_frame && (CPHA ? trail_edge : lead_edge);
    // The first bit of a word is already on MISO from the reload.
    shift_evt  = in_frame && (CPHA ? lead_edge : trail_edge) && (bit_cnt_q != '0);
    cs_fall    = !active_q && cs_idle_q && !cs_s;
    cs_rise    = active_q && cs_s;
    word_done  = sample_evt && (bit_cnt_q == LAST_BIT);
    reload     = cs_fall || word_done;
    hold_wr    = tx_valid && !hold_full_q;
    rx_next    = MSB_FIRST ? {rx_shift_q[WIDTH-2:0], mosi_s} : {mosi_s, rx_shift_q[WIDTH-1:1]};
  end

  assign tx_ready    = !hold_full_q;
  assign spi_miso_oe = active_q;

  // All state: synchronisers, frame tracking, shift registers, holding register and pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cs_sync_q   <= '1;
      sclk_sync_q <= {SYNC_STAGES{CPOL}};
      mosi_sync_q <= '0;
      sclk_dly_q  <= CPOL;
      flush_cnt_q <= '0;
      cs_idle_q   <= 1'b0;
      active_q    <= 1'b0;
      bit_cnt_q   <= '0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      spi_miso    <= 1'b0;
      rx_valid    <= 1'b0;
      rx_data     <= '0;
      tx_underrun <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs};
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_clk};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      sclk_dly_q  <= sclk_s;
      // Until the reset presets have flushed out, a low CS cannot count as a fall.
      if (!flushed) flush_cnt_q <= flush_cnt_q + FLUSH_W'(1);
      cs_idle_q   <= flushed && cs_s;

      frame_start <= cs_fall;
      frame_end   <= cs_rise;
      frame_err   <= cs_rise && (bit_cnt_q != '0);
      rx_valid    <= word_done;
      tx_underrun <= reload && !hold_full_q;

      if (cs_fall)      active_q <= 1'b1;
      else if (cs_rise) active_q <= 1'b0;

      if (cs_rise)         bit_cnt_q <= '0;
      else if (word_done)  bit_cnt_q <= '0;
      else if (sample_evt) bit_cnt_q <= bit_cnt_q + CNT_W'(1);

      if (sample_evt) rx_shift_q <= rx_next;
      if (word_done)  rx_data    <= rx_next;

      if (reload) begin
        tx_shift_q <= hold_full_q ? hold_q : TX_IDLE;
      end else if (shift_evt) begin
        tx_shift_q <= MSB_FIRST ? {tx_shift_q[WIDTH-2:0], 1'b0} : {1'b0, tx_shift_q[WIDTH-1:1]};
      end

      // A write can only land while empty, so it never collides with a reload from full.
      if (hold_wr) begin
        hold_q      <= tx_data;
        hold_full_q <= 1'b1;
      end else if (reload) begin
        hold_full_q <= 1'b0;
      end

      spi_miso <= MSB_FIRST ? tx_shift_q[WIDTH-1] : tx_shift_q[0];
    end
  end

endmodule

// File: tb/tb_spi_slave_phy_sync.sv
// Directed bench for spi_slave_phy_sync: three instances cover mode 0 / 8 bit,
// mode 3 / 8 bit and mode 1 / 16 bit LSB-first. SCLK period is 8 clk periods.
`timescale 1ns / 1ps

module tb_spi_slave_phy_sync;

  logic clk;
  logic rst_n;
  logic mosi;
  logic cs[3];
  logic sclk[3];
  logic miso[3], oe[3], rxv[3], tv[3], txr[3], und[3], fs[3], fe[3], ferr[3];
  logic [7:0]  rxd0, rxd1, txd0, txd1;
  logic [15:0] rxd2, txd2;

  int n_cmp, n_bad;
  int rx_cnt[3], und_cnt[3], fs_cnt[3], fe_cnt[3], ferr_cnt[3], joint_cnt[3];
  logic [7:0]  rx_log0[$];
  logic [7:0]  rx_log1[$];
  logic [15:0] rx_log2[$];

  spi_slave_phy_sync u_dut0 (
    .clk(clk), .rst_n(rst_n), .spi_cs(cs[0]), .spi_clk(sclk[0]), .spi_mosi(mosi),
    .spi_miso(miso[0]), .spi_miso_oe(oe[0]), .rx_valid(rxv[0]), .rx_data(rxd0),
    .tx_valid(tv[0]), .tx_ready(txr[0]), .tx_data(txd0), .tx_underrun(und[0]),
    .frame_start(fs[0]), .frame_end(fe[0]), .frame_err(ferr[0])
  );

  spi_slave_phy_sync #(.CPOL(1'b1), .CPHA(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .spi_cs(cs[1]), .spi_clk(sclk[1]), .spi_mosi(mosi),
    .spi_miso(miso[1]), .spi_miso_oe(oe[1]), .rx_valid(rxv[1]), .rx_data(rxd1),
    .tx_valid(tv[1]), .tx_ready(txr[1]), .tx_data(txd1), .tx_underrun(und[1]),
    .frame_start(fs[1]), .frame_end(fe[1]), .frame_err(ferr[1])
  );

  spi_slave_phy_sync #(.WIDTH(16), .CPOL(1'b0), .CPHA(1'b1), .MSB_FIRST(1'b0),
                       .TX_IDLE(16'hFFFF)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .spi_cs(cs[2]), .spi_clk(sclk[2]), .spi_mosi(mosi),
    .spi_miso(miso[2]), .spi_miso_oe(oe[2]), .rx_valid(rxv[2]), .rx_data(rxd2),
    .tx_valid(tv[2]), .tx_ready(txr[2]), .tx_data(txd2), .tx_underrun(und[2]),
    .frame_start(fs[2]), .frame_end(fe[2]), .frame_err(ferr[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters and received-word logs, sampled mid-cycle.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rxv[i])          rx_cnt[i]++;
      if (und[i])          und_cnt[i]++;
      if (fs[i])           fs_cnt[i]++;
      if (fe[i])           fe_cnt[i]++;
      if (ferr[i])         ferr_cnt[i]++;
      if (fe[i] && ferr[i]) joint_cnt[i]++;
    end
    if (rxv[0]) rx_log0.push_back(rxd0);
    if (rxv[1]) rx_log1.push_back(rxd1);
    if (rxv[2]) rx_log2.push_back(rxd2);
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Offer one word to the holding register once it is empty (bounded wait).
  task automatic tx_write(input int idx, input logic [15:0] d);
    int n;
    n = 0;
    @(negedge clk);
    while (!txr[idx] && n < 400) begin
      @(negedge clk);
      n++;
    end
    check_eq("tx_ready_seen", 32'(txr[idx]), 32'd1);
    case (idx)
      0:       txd0 = d[7:0];
      1:       txd1 = d[7:0];
      default: txd2 = d;
    endcase
    tv[idx] = 1'b1;
    @(negedge clk);
    tv[idx] = 1'b0;
  endtask

  task automatic frame_open(input int idx);
    #($urandom_range(0, 9));
    cs[idx] = 1'b0;
    #80;
  endtask

  task automatic frame_close(input int idx);
    #40;
    cs[idx] = 1'b1;
    #100;
  endtask

  // SPI master: half period 40 ns, MISO captured 20 ns after each sample edge.
  task automatic xfer(input int idx, input bit cpol, input bit cpha, input bit msb,
                      input int width, input int nbits, input logic [31:0] mo,
                      output logic [31:0] mi);
    mi = '0;
    for (int i = 0; i < nbits; i++) begin
      int b;
      b = msb ? (width - 1 - i) : i;
      if (!cpha) begin
        mosi = mo[b];
        #40 sclk[idx] = ~cpol;
        #20 mi[b] = miso[idx];
        #20 sclk[idx] = cpol;
      end else begin
        sclk[idx] = ~cpol;
        mosi = mo[b];
        #40 sclk[idx] = cpol;
        #20 mi[b] = miso[idx];
        #20;
      end
    end
  endtask

  logic [31:0] mi_a, mi_b;
  logic [7:0]  rnd_mo[256];
  logic [7:0]  rnd_tx[256];
  int b_rx, b_und, b_fs, b_fe, b_ferr, b_joint, b_log;

  initial begin
    rst_n = 1'b0;
    mosi  = 1'b0;
    txd0 = '0; txd1 = '0; txd2 = '0;
    for (int i = 0; i < 3; i++) begin
      cs[i] = 1'b1;
      tv[i] = 1'b0;
    end
    sclk[0] = 1'b0; sclk[1] = 1'b1; sclk[2] = 1'b0;
    repeat (4) @(negedge clk);

    // Reset state
    check_eq("rst_miso", 32'(miso[0]), 32'd0);
    check_eq("rst_oe", 32'(oe[0]), 32'd0);
    check_eq("rst_tx_ready", 32'(txr[0]), 32'd1);
    check_eq("rst_rx_data", 32'(rxd0), 32'd0);
    check_eq("rst_pulses", 32'({rxv[0], und[0], fs[0], fe[0], ferr[0]}), 32'd0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // Mode 0: 0x3C preloaded, master sends 0xA5, 0x5A. After the first underrun a
    // filler word is queued so the second word's reload does not underrun as well.
    tx_write(0, 16'h003C);
    b_rx = rx_cnt[0]; b_und = und_cnt[0]; b_fs = fs_cnt[0]; b_fe = fe_cnt[0];
    b_ferr = ferr_cnt[0]; b_log = rx_log0.size();
    frame_open(0);
    check_eq("m0_oe_in_frame", 32'(oe[0]), 32'd1);
    fork
      begin
        xfer(0, 1'b0, 1'b0, 1'b1, 8, 8, 32'hA5, mi_a);
        xfer(0, 1'b0, 1'b0, 1'b1, 8, 8, 32'h5A, mi_b);
      end
      begin : m0_feed
        int n;
        n = 0;
        while (und_cnt[0] == b_und && n < 400) begin
          @(negedge clk);
          n++;
        end
        tx_write(0, 16'h0000);
      end
    join
    frame_close(0);
    check_eq("m0_rx_count", 32'(rx_cnt[0] - b_rx), 32'd2);
    check_eq("m0_rx_word0", 32'(rx_log0[b_log]), 32'hA5);
    check_eq("m0_rx_word1", 32'(rx_log0[b_log + 1]), 32'h5A);
    check_eq("m0_miso_word0", mi_a, 32'h3C);
    check_eq("m0_miso_word1", mi_b, 32'hFF);
    check_eq("m0_underruns", 32'(und_cnt[0] - b_und), 32'd1);
    check_eq("m0_frame_start", 32'(fs_cnt[0] - b_fs), 32'd1);
    check_eq("m0_frame_end", 32'(fe_cnt[0] - b_fe), 32'd1);
    check_eq("m0_frame_err", 32'(ferr_cnt[0] - b_ferr), 32'd0);
    check_eq("m0_oe_after", 32'(oe[0]), 32'd0);

    // Mode 3: 0x81 then 0x7E fed back-to-back via tx_ready; a filler keeps word 2 clean.
    tx_write(1, 16'h0081);
    b_rx = rx_cnt[1]; b_und = und_cnt[1]; b_log = rx_log1.size();
    frame_open(1);
    fork
      begin
        xfer(1, 1'b1, 1'b1, 1'b1, 8, 8, 32'h3A, mi_a);
        xfer(1, 1'b1, 1'b1, 1'b1, 8, 8, 32'hC5, mi_b);
      end
      begin
        tx_write(1, 16'h007E);
        tx_write(1, 16'h0000);
      end
    join
    frame_close(1);
    check_eq("m3_miso_word0", mi_a, 32'h81);
    check_eq("m3_miso_word1", mi_b, 32'h7E);
    check_eq("m3_underruns", 32'(und_cnt[1] - b_und), 32'd0);
    check_eq("m3_rx_count", 32'(rx_cnt[1] - b_rx), 32'd2);
    check_eq("m3_rx_word0", 32'(rx_log1[b_log]), 32'h3A);
    check_eq("m3_rx_word1", 32'(rx_log1[b_log + 1]), 32'hC5);

    // Mode 1, 16 bit, LSB first. Completion reloads from an empty holding register.
    tx_write(2, 16'hBEEF);
    b_rx = rx_cnt[2]; b_und = und_cnt[2]; b_log = rx_log2.size();
    frame_open(2);
    xfer(2, 1'b0, 1'b1, 1'b0, 16, 16, 32'h1234, mi_a);
    frame_close(2);
    check_eq("w16_rx_count", 32'(rx_cnt[2] - b_rx), 32'd1);
    check_eq("w16_rx_word", 32'(rx_log2[b_log]), 32'h1234);
    check_eq("w16_miso", mi_a, 32'hBEEF);
    check_eq("w16_underruns", 32'(und_cnt[2] - b_und), 32'd1);

    // Partial frame: CS rises after 5 bits, then a clean word.
    b_rx = rx_cnt[0]; b_fe = fe_cnt[0]; b_ferr = ferr_cnt[0]; b_joint = joint_cnt[0];
    frame_open(0);
    xfer(0, 1'b0, 1'b0, 1'b1, 8, 5, 32'hA5, mi_a);
    frame_close(0);
    check_eq("part_frame_err", 32'(ferr_cnt[0] - b_ferr), 32'd1);
    check_eq("part_frame_end", 32'(fe_cnt[0] - b_fe), 32'd1);
    check_eq("part_same_cycle", 32'(joint_cnt[0] - b_joint), 32'd1);
    check_eq("part_no_rx", 32'(rx_cnt[0] - b_rx), 32'd0);
    b_log = rx_log0.size();
    frame_open(0);
    xfer(0, 1'b0, 1'b0, 1'b1, 8, 8, 32'h96, mi_a);
    frame_close(0);
    check_eq("part_next_rx", 32'(rx_log0[b_log]), 32'h96);
    check_eq("part_next_miso", mi_a, 32'hFF);

    // Reset mid-frame with CS held low; holding register is full when reset hits.
    frame_open(0);
    tx_write(0, 16'h0055);
    xfer(0, 1'b0, 1'b0, 1'b1, 8, 3, 32'hE0, mi_a);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("mrst_oe", 32'(oe[0]), 32'd0);
    check_eq("mrst_miso", 32'(miso[0]), 32'd0);
    check_eq("mrst_tx_ready", 32'(txr[0]), 32'd1);
    check_eq("mrst_rx_data", 32'(rxd0), 32'd0);
    check_eq("mrst_pulses", 32'({rxv[0], und[0], fs[0], fe[0], ferr[0]}), 32'd0);
    rst_n = 1'b1;
    b_fs = fs_cnt[0];
    repeat (20) @(negedge clk);
    check_eq("mrst_no_fs_low_cs", 32'(fs_cnt[0] - b_fs), 32'd0);
    check_eq("mrst_oe_low_cs", 32'(oe[0]), 32'd0);
    cs[0] = 1'b1;
    #100;
    b_log = rx_log0.size();
    frame_open(0);
    check_eq("mrst_fs_after_cycle", 32'(fs_cnt[0] - b_fs), 32'd1);
    check_eq("mrst_oe_after_cycle", 32'(oe[0]), 32'd1);
    xfer(0, 1'b0, 1'b0, 1'b1, 8, 8, 32'h3C, mi_a);
    frame_close(0);
    check_eq("mrst_rx", 32'(rx_log0[b_log]), 32'h3C);
    check_eq("mrst_miso_idle", mi_a, 32'hFF);

    // Random loopback: 4 frames x 64 words, random clk phase per frame.
    for (int i = 0; i < 256; i++) begin
      rnd_mo[i] = 8'($urandom);
      rnd_tx[i] = 8'($urandom);
    end
    for (int f = 0; f < 4; f++) begin
      b_und = und_cnt[0]; b_log = rx_log0.size();
      tx_write(0, {8'h00, rnd_tx[f * 64]});
      frame_open(0);
      fork
        begin
          for (int k = 0; k < 64; k++) begin
            xfer(0, 1'b0, 1'b0, 1'b1, 8, 8, {24'h0, rnd_mo[f * 64 + k]}, mi_b);
            check_eq("rnd_miso", mi_b, {24'h0, rnd_tx[f * 64 + k]});
          end
        end
        begin
          for (int k = 1; k < 64; k++) tx_write(0, {8'h00, rnd_tx[f * 64 + k]});
          tx_write(0, 16'h0000);
        end
      join
      frame_close(0);
      for (int k = 0; k < 64; k++) begin
        check_eq("rnd_rx", 32'(rx_log0[b_log + k]), 32'(rnd_mo[f * 64 + k]));
      end
      check_eq("rnd_underruns", 32'(und_cnt[0] - b_und), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_slave_phy_sync.md
Name: spi_slave_phy_sync

Overview:
- Next-generation SPI slave PHY for the USB-to-SPI bridge path.
- Oversamples SCLK, CS and MOSI in the system clock domain, so there is no SCLK-clocked logic and no latch.
- Supports all four SPI modes, a parametrised word width and bit order, and a flow-controlled transmit holding register.
- Feeds word-level rx/tx handshakes to the protocol layer above.

Parameters:
- WIDTH, 8: bits per SPI word (4..32).
- CPOL, 0: SCLK idle level.
- CPHA, 0: 0 = sample on leading edge; 1 = sample on trailing edge.
- MSB_FIRST, 1: 1 = shift MSB first; 0 = shift LSB first.
- SYNC_STAGES, 2: synchroniser depth for spi_clk, spi_cs and spi_mosi (>= 2).
- TX_IDLE, all ones (WIDTH bits): word shifted out when the holding register is empty.

Ports:
- clk  in  1  system clock; must run >= 8x SCLK.
- rst_n  in  1  synchronous active-low reset.
- spi_cs  in  1  chip select; high = deselected.
- spi_clk  in  1  SPI serial clock (asynchronous).
- spi_mosi  in  1  serial data in.
- spi_miso  out  1  serial data out.
- spi_miso_oe  out  1  MISO output enable; 1 while selected.
- rx_valid  out  1  one-cycle pulse: rx_data holds a complete word.
- rx_data  out  WIDTH  received word.
- tx_valid  in  1  tx_data offered.
- tx_ready  out  1  holding register empty.
- tx_data  in  WIDTH  word to transmit.
- tx_underrun  out  1  one-cycle pulse: TX_IDLE was loaded because holding was empty.
- frame_start  out  1  one-cycle pulse on synchronised CS fall.
- frame_end  out  1  one-cycle pulse on synchronised CS rise.
- frame_err  out  1  one-cycle pulse: CS rose with a partial word pending.

Behaviour:
- Reset is synchronous on clk with rst_n=0.
  - All pulses 0, rx_data 0, spi_miso 0, spi_miso_oe 0, tx_ready 1.
  - Holding register empty, bit counter 0, shift registers 0.
  - Synchronisers preset to the idle state: cs=1, sclk=CPOL.
- Synchronisation and edge detection:
  - Each input passes through SYNC_STAGES flops.
  - An edge is detected from the last synchronised stage versus one extra delayed flop.
  - Leading edge = transition away from CPOL; trailing edge = transition back.
  - Sample edge = leading if CPHA=0, else trailing. Shift edge = the other edge.
- While synchronised cs=1:
  - All SCLK edges are ignored and the bit counter is held at 0.
  - spi_miso_oe=0.
- Frame start (synchronised cs 1->0):
  - frame_start pulses.
  - spi_miso_oe=1 in the same cycle.
  - The tx shift register loads, see the reload rule below.
- Sample edge: shift the synchronised MOSI in (at LSB if MSB_FIRST, else at MSB) and increment the bit counter.
- Word completion, when bit counter == WIDTH-1 at a sample edge:
  - Bit counter wraps to 0.
  - Next cycle: rx_valid=1 and rx_data = the assembled word.
  - The tx shift register reloads in the same cycle.
  - rx has no backpressure; rx_data holds until the next word completes.
- Shift edge: shift tx out only if bit counter != 0; the first bit of each word is presented at load time.
  - spi_miso = shift register MSB (MSB_FIRST=1) or LSB (MSB_FIRST=0), registered.
  - Latency from the raw SCLK edge to a MISO update is SYNC_STAGES+2 clk cycles.
- Tx reload rule:
  - If the holding register is full at the start of the cycle: load it, mark it empty, and tx_ready=1 from the next cycle.
  - Otherwise load TX_IDLE and pulse tx_underrun.
- Holding register:
  - Writes when tx_valid && tx_ready; tx_ready=0 the next cycle.
  - A write and an empty-holding reload in the same cycle: the reload uses TX_IDLE, and the write lands in holding for the next word.
  - Holding content survives CS deassertion; it is the first word of the next frame.
- Frame end (synchronised cs 0->1):
  - frame_end pulses and spi_miso_oe=0.
  - If bit counter != 0: frame_err pulses in the same cycle, the partial word is discarded (no rx_valid) and the bit counter clears.
- Simultaneous sample edge and CS rise in the same cycle: CS rise wins and the edge is ignored.
- Reset mid-frame: all state clears. The first CS fall seen after release starts a fresh frame; an already-low CS gives no frame_start until it rises and falls again.

Test Plan:
- Mode 0, WIDTH=8:
  - Stimulus: tx_data=0x3C preloaded; master sends 0xA5, then 0x5A in one frame.
  - Required: rx_valid twice with 0xA5 then 0x5A; MISO 0x3C then 0xFF; one tx_underrun; frame_start and frame_end once each.
- Mode 3 (CPOL=1, CPHA=1):
  - Stimulus: tx_data 0x81 and 0x7E written back-to-back using tx_ready.
  - Required: MISO yields 0x81, 0x7E; no underrun; rx matches the MOSI bytes.
- WIDTH=16, MSB_FIRST=0, mode 1:
  - Stimulus: MOSI sends 0x1234 LSB first; tx 0xBEEF.
  - Required: rx_data=0x1234; MISO bit sequence equals 0xBEEF LSB first.
- Partial frame:
  - Stimulus: CS rises after 5 bits.
  - Required: frame_err=1 and frame_end=1 in the same cycle; no rx_valid; next frame's first word is received correctly.
- Reset mid-frame:
  - Stimulus: rst_n low for 2 clk after 3 bits, while CS stays low.
  - Required: all outputs return to reset values; no frame_start until CS cycles high then low.
- Clock ratio:
  - Stimulus: clk = 8x SCLK with random phase.
  - Required: 256 random words loop back with no bit error.
